// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the MIPS front end.
package mips_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  typedef enum logic {
    ISSUE,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Instruction queue: small synchronous FIFO of fetched {addr, instr} entries.
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(QDEPTH):0]  count,
  output fetch_entry_t             head
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  fetch_entry_t    mem [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC write port, issues single
// outstanding imem reads, and queues returned words toward decode.
module ifetch_ctrl #(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCResult,
  output logic [ADDR_W-1:0] PC_Next,
  output logic              w_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              IF_valid,
  output logic [31:0]       IF_instr,
  output logic [ADDR_W-1:0] IF_pc,
  input  logic              IF_ready,
  output logic              misalign_err
);

  import mips_pkg::*;

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  fetch_state_t      state, state_nx;
  logic              kill, kill_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              push, pop, flush;
  logic [CW-1:0]     count;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  assign push_data = '{addr: addr_q, instr: imem_rdata};

  ifetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (CLK),
    .rst       (Reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  assign IF_valid = (count != '0);
  assign IF_instr = head.instr;
  assign IF_pc    = head.addr;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= ISSUE;
      kill   <= 1'b0;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      kill   <= kill_nx;
      addr_q <= addr_nx;
    end
  end

  // Outputs are combinational, so they are forced low while Reset is held.
  always_comb begin
    state_nx     = state;
    kill_nx      = kill;
    addr_nx      = addr_q;
    imem_req     = 1'b0;
    imem_addr    = '0;
    w_en         = 1'b0;
    PC_Next      = '0;
    misalign_err = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    if (!Reset) begin
      pop = IF_valid && IF_ready;
      if (br_taken) begin
        w_en         = 1'b1;
        PC_Next      = {br_target[ADDR_W-1:2], 2'b00};
        misalign_err = (br_target[1:0] != 2'b00);
        flush        = 1'b1;
        if (state == WAIT) begin
          if (imem_rvalid) begin
            state_nx = ISSUE;
            kill_nx  = 1'b0;
          end else begin
            kill_nx  = 1'b1;
          end
        end
      end else begin
        unique case (state)
          ISSUE: begin
            if (count < FULL) begin
              imem_req  = 1'b1;
              imem_addr = PCResult;
              w_en      = 1'b1;
              PC_Next   = PCResult + ADDR_W'(PC_INC);
              addr_nx   = PCResult;
              state_nx  = WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              push     = !kill;
              kill_nx  = 1'b0;
              state_nx = ISSUE;
            end
          end
          default: state_nx = ISSUE;
        endcase
      end
    end
  end

endmodule
